// File: rtl/video_timing_detect.sv
// rtl/video_timing_detect.sv - video stream geometry monitor with raster check and lock
// Measures line/frame timing of a vsync/hsync/valid/data stream and locks once it matches the expected raster.
module video_timing_detect #(
  parameter int H_TOTAL     = 1650,
  parameter int H_DISP      = 1280,
  parameter int V_TOTAL     = 750,
  parameter int V_DISP      = 720,
  parameter int LOCK_FRAMES = 2,
  parameter int CNT_W       = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             img_vsync,
  input  logic             img_hsync,
  input  logic             img_valid,
  input  logic [7:0]       img_data,
  output logic             frame_done,
  output logic [CNT_W-1:0] meas_h_total,
  output logic [CNT_W-1:0] meas_h_active,
  output logic [CNT_W-1:0] meas_v_total,
  output logic [CNT_W-1:0] meas_v_active,
  output logic [31:0]      frame_sum,
  output logic             mismatch,
  output logic             locked,
  output logic [15:0]      err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam int GW = $clog2(LOCK_FRAMES + 1);

  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  logic             vs_d1, vs_d2, hs_d1, hs_d2, valid_d1;
  logic [7:0]       data_d1;
  logic             hs_rise, vs_rise, h_sat, hunt_force, line_close;
  logic [CNT_W-1:0] h_cnt, line_len, pix_cnt, last_act, act_lines, line_cnt;
  logic [31:0]      sum, pix_val;
  logic             line_err, sat;
  logic [CNT_W-1:0] last_act_c, act_lines_c, line_cnt_c;
  logic             line_err_c, sat_c;
  logic             close_s1, close_s2, match_s2, snap_bad;
  logic [CNT_W-1:0] snap_h_total, snap_h_active, snap_v_total, snap_v_active;
  logic [31:0]      snap_sum;
  state_t           state, state_n;
  logic [GW-1:0]    good, good_n;
  logic [GW:0]      good_inc;
  logic [15:0]      err_n;

  assign hs_rise    = hs_d1 & ~hs_d2;
  assign vs_rise    = vs_d1 & ~vs_d2;
  assign h_sat      = (h_cnt == CNT_MAX);
  assign hunt_force = h_sat & ~hs_rise;
  assign line_close = hs_rise & (pix_cnt != '0);
  assign pix_val    = valid_d1 ? {24'd0, data_d1} : 32'd0;

  // Line-close results forwarded so a coincident vsync closes the frame with this line included.
  assign last_act_c  = line_close ? pix_cnt : last_act;
  assign act_lines_c = line_close ? sat_inc(act_lines) : act_lines;
  assign line_cnt_c  = hs_rise ? sat_inc(line_cnt) : line_cnt;
  assign line_err_c  = line_err | (line_close & (pix_cnt != CNT_W'(H_DISP)));
  assign sat_c       = sat | h_sat | (pix_cnt == CNT_MAX) | (line_cnt_c == CNT_MAX) |
                       (act_lines_c == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_d1 <= 1'b0; vs_d2 <= 1'b0; hs_d1 <= 1'b0; hs_d2 <= 1'b0;
      valid_d1 <= 1'b0; data_d1 <= 8'd0;
    end else begin
      vs_d1 <= img_vsync; vs_d2 <= vs_d1;
      hs_d1 <= img_hsync; hs_d2 <= hs_d1;
      valid_d1 <= img_valid; data_d1 <= img_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0; line_len <= '0; pix_cnt <= '0; last_act <= '0;
      act_lines <= '0; line_cnt <= '0; sum <= 32'd0; line_err <= 1'b0; sat <= 1'b0;
    end else begin
      h_cnt <= hs_rise ? CNT_W'(1) : sat_inc(h_cnt);
      if (hs_rise) line_len <= h_cnt;
      if (hs_rise) pix_cnt <= CNT_W'(valid_d1);
      else if (valid_d1) pix_cnt <= sat_inc(pix_cnt);
      if (vs_rise) begin
        last_act <= '0; act_lines <= '0; line_cnt <= '0;
        line_err <= 1'b0; sat <= 1'b0; sum <= pix_val;
      end else begin
        last_act <= last_act_c; act_lines <= act_lines_c; line_cnt <= line_cnt_c;
        line_err <= line_err_c; sat <= sat_c; sum <= sum + pix_val;
      end
    end
  end

  // Close pipeline: snapshot, evaluate match, publish.
  always_ff @(posedge clk) begin
    if (rst) begin
      close_s1 <= 1'b0; close_s2 <= 1'b0; match_s2 <= 1'b0; snap_bad <= 1'b0;
      snap_h_total <= '0; snap_h_active <= '0; snap_v_total <= '0; snap_v_active <= '0;
      snap_sum <= 32'd0;
    end else begin
      close_s1 <= vs_rise & (state != HUNT) & ~hunt_force;
      close_s2 <= close_s1 & ~hunt_force;
      if (vs_rise) begin
        snap_h_total  <= hs_rise ? h_cnt : line_len;
        snap_h_active <= last_act_c;
        snap_v_total  <= line_cnt_c;
        snap_v_active <= act_lines_c;
        snap_sum      <= sum;
        snap_bad      <= line_err_c | sat_c;
      end
      match_s2 <= (snap_h_total == CNT_W'(H_TOTAL)) && (snap_h_active == CNT_W'(H_DISP)) &&
                  (snap_v_total == CNT_W'(V_TOTAL)) && (snap_v_active == CNT_W'(V_DISP)) &&
                  !snap_bad;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HUNT;
      good  <= '0;
    end else begin
      state <= state_n;
      good  <= good_n;
    end
  end

  always_comb begin
    state_n  = state;
    good_n   = good;
    err_n    = err_cnt;
    good_inc = {1'b0, good} + (GW+1)'(1);
    if (hunt_force) begin
      state_n = HUNT;
      good_n  = '0;
    end else begin
      case (state)
        HUNT: if (vs_rise) begin
          state_n = CHECK;
          good_n  = '0;
        end
        CHECK: if (close_s2) begin
          if (!match_s2) good_n = '0;
          else if (good_inc == (GW+1)'(LOCK_FRAMES)) begin
            state_n = LOCKED;
            good_n  = '0;
          end else good_n = good_inc[GW-1:0];
        end
        LOCKED: if (close_s2 && !match_s2) begin
          state_n = CHECK;
          good_n  = '0;
          if (err_cnt != 16'hFFFF) err_n = err_cnt + 16'd1;
        end
        default: state_n = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_done <= 1'b0; locked <= 1'b0; err_cnt <= 16'd0; mismatch <= 1'b0;
      meas_h_total <= '0; meas_h_active <= '0; meas_v_total <= '0; meas_v_active <= '0;
      frame_sum <= 32'd0;
    end else begin
      frame_done <= close_s2 & ~hunt_force;
      locked     <= (state_n == LOCKED);
      err_cnt    <= err_n;
      if (close_s2 && !hunt_force) begin
        meas_h_total  <= snap_h_total;
        meas_h_active <= snap_h_active;
        meas_v_total  <= snap_v_total;
        meas_v_active <= snap_v_active;
        frame_sum     <= snap_sum;
        mismatch      <= ~match_s2;
      end
    end
  end

endmodule
